// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RISC-V instruction fields into I/S/SB words,
// rejects out-of-range or inconsistent requests, and streams accepted words
// into instruction memory through a one-entry registered write port.
module inst_encoder #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            fmt,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [63:0]           imm,
  output logic                  wr_en,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  full,
  output logic                  err,
  output logic [7:0]            err_count
);

  // Instruction formats understood by the encoder; the last code is reserved.
  typedef enum logic [1:0] {
    FMT_I   = 2'b00,
    FMT_S   = 2'b01,
    FMT_SB  = 2'b10,
    FMT_RSV = 2'b11
  } fmt_e;

  // Highest word address in memory; completing a write here marks memory full.
  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR  = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);

  logic        out_valid;
  logic        imm_in_range;
  logic        opcode_ok;
  logic        reject;
  logic        accept;
  logic        wr_done;
  logic [31:0] enc_word;

  // The immediate must fit a 12-bit signed field: all upper bits copy bit 11.
  assign imm_in_range = (imm[63:11] == {53{imm[11]}});

  // Pack the fields for the requested format and check opcode/format agreement.
  always_comb begin
    opcode_ok = 1'b0;
    enc_word  = '0;
    case (fmt)
      FMT_I: begin
        opcode_ok = (opcode[6:5] == 2'b00);
        enc_word  = {imm[11:0], rs1, funct3, rd, opcode};
      end
      FMT_S: begin
        opcode_ok = (opcode[6:5] == 2'b01);
        enc_word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      FMT_SB: begin
        opcode_ok = opcode[6];
        enc_word  = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
      end
      default: begin
        opcode_ok = 1'b0;
        enc_word  = '0;
      end
    endcase
  end

  assign reject = (fmt == FMT_RSV) || !imm_in_range || !opcode_ok;

  // A new request may enter when the output slot is empty or draining this cycle.
  assign in_ready = !full && !clr && (!out_valid || wr_ready);
  assign accept   = in_valid && in_ready;
  assign wr_done  = out_valid && wr_ready;
  assign wr_en    = out_valid;

  // One-entry output slot: load on a good request, empty when the write drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      wr_data   <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else if (accept && !reject) begin
      out_valid <= 1'b1;
      wr_data   <= enc_word;
    end else if (wr_done) begin
      out_valid <= 1'b0;
    end
  end

  // Advance the write address per completed write and flag full at the top word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr <= '0;
      full    <= 1'b0;
    end else if (clr) begin
      wr_addr <= '0;
      full    <= 1'b0;
    end else if (wr_done) begin
      wr_addr <= wr_addr + ADDR_STEP;
      if (wr_addr == TOP_ADDR) begin
        full <= 1'b1;
      end
    end
  end

  // Record rejected requests in a sticky flag and a saturating counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err       <= 1'b0;
      err_count <= 8'd0;
    end else if (clr) begin
      err       <= 1'b0;
      err_count <= 8'd0;
    end else if (accept && reject) begin
      err <= 1'b1;
      if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
